// File: rtl/freq_code_detector_pkg.sv
// Shared divider/detector constants: counter width, code shift, period limits and load formula.
package freq_code_detector_pkg;

  localparam int unsigned M        = 9;
  localparam int unsigned K        = 5;
  localparam int unsigned CW       = 3;
  localparam int unsigned PW       = M + 1;
  localparam int unsigned SW       = M + 2;
  localparam int unsigned P_BASE   = 1 << M;
  localparam int unsigned CODE_MAX = (1 << CW) - 1;
  localparam int unsigned P_SPAN   = CODE_MAX << K;
  localparam int unsigned HALF     = 1 << (K - 1);
  localparam int unsigned P_MIN    = P_BASE - P_SPAN;
  localparam int unsigned P_MAX    = P_BASE;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] code;
  } decode_t;

  function automatic int unsigned p_min(input int unsigned tol);
    return P_BASE - P_SPAN - tol;
  endfunction

  function automatic int unsigned p_max(input int unsigned tol);
    return P_BASE + tol;
  endfunction

  // Divider reload value {0, code, K zeros}; kept here so both blocks share one formula.
  function automatic logic [M-1:0] div_load(input logic [CW-1:0] c);
    return M'({c, {K{1'b0}}});
  endfunction

endpackage

// File: rtl/freq_code_detector_if.sv
// Pulse input and decoded-result outputs of the frequency code detector.
interface freq_code_detector_if;
  import freq_code_detector_pkg::*;

  logic          pulse_in;
  logic [CW-1:0] code;
  logic          code_vld;
  logic [PW-1:0] period;
  logic          err;
  logic          locked;

  modport master (output pulse_in, input code, code_vld, period, err, locked);
  modport slave  (input pulse_in, output code, code_vld, period, err, locked);

endinterface

// File: rtl/freq_code_detector_period_to_code.sv
// Combinational period -> code decoder with range and residual checks.
module freq_code_detector_period_to_code
  import freq_code_detector_pkg::*;
#(
  parameter int unsigned TOL = 0
) (
  input  logic [PW-1:0] p,
  output decode_t       dec
);

  logic signed [SW-1:0] d;
  logic signed [SW-1:0] cs;
  logic signed [SW-1:0] resid;
  logic                 in_range;
  logic                 res_ok;
  logic                 code_ok;

  // Round-to-nearest code, then require the residual to sit within tolerance.
  always_comb begin
    d        = $signed(SW'(P_BASE)) - $signed(SW'(p));
    cs       = (d + $signed(SW'(HALF))) >>> K;
    resid    = d - (cs <<< K);
    in_range = (p >= PW'(p_min(TOL))) && (p <= PW'(p_max(TOL)));
    res_ok   = (resid <= $signed(SW'(TOL))) && (resid >= -$signed(SW'(TOL)));
    code_ok  = !cs[SW-1] && (cs <= $signed(SW'(CODE_MAX)));
    dec.valid = in_range && res_ok && code_ok;
    dec.code  = cs[CW-1:0];
  end

endmodule

// File: rtl/freq_code_detector.sv
// Measures the rising-edge period of a divider pulse train and decodes it back into its code.
module freq_code_detector
  import freq_code_detector_pkg::*;
#(
  parameter int unsigned TOL    = 0,
  parameter int unsigned LOCK_N = 4
) (
  input logic                 clk,
  input logic                 rst,
  freq_code_detector_if.slave bus
);

  localparam int unsigned   MW   = 4;
  localparam logic [0:0]    IDLE = 1'b0;
  localparam logic [0:0]    MEAS = 1'b1;
  localparam logic [PW-1:0] TMO  = PW'(p_max(TOL) + 1);

  logic [0:0]    state_q, state_d;
  logic          pulse_prev;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] code_q, code_d;
  logic          vld_q, vld_d;
  logic [PW-1:0] period_q, period_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic [MW-1:0] match_q, match_d;
  logic          rise;
  decode_t       dec;

  freq_code_detector_period_to_code #(.TOL(TOL)) u_dec (
    .p   (pcnt_q),
    .dec (dec)
  );

  assign rise = bus.pulse_in & ~pulse_prev;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    code_d   = code_q;
    vld_d    = 1'b0;
    period_d = period_q;
    err_d    = 1'b0;
    match_d  = match_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          pcnt_d  = PW'(1);
          state_d = MEAS;
        end
      end
      MEAS: begin
        // An edge always closes a measurement, even on the timeout cycle.
        if (rise) begin
          period_d = pcnt_q;
          pcnt_d   = PW'(1);
          if (dec.valid) begin
            code_d = dec.code;
            vld_d  = 1'b1;
            if ((match_q != '0) && (dec.code == code_q))
              match_d = (match_q >= MW'(LOCK_N)) ? match_q : match_q + MW'(1);
            else
              match_d = MW'(1);
          end else begin
            err_d   = 1'b1;
            match_d = '0;
          end
        end else if (pcnt_q == TMO) begin
          err_d   = 1'b1;
          match_d = '0;
          pcnt_d  = '0;
          state_d = IDLE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (match_d >= MW'(LOCK_N));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pulse_prev <= 1'b0;
      pcnt_q     <= '0;
      code_q     <= '0;
      vld_q      <= 1'b0;
      period_q   <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      pulse_prev <= bus.pulse_in;
      pcnt_q     <= pcnt_d;
      code_q     <= code_d;
      vld_q      <= vld_d;
      period_q   <= period_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      match_q    <= match_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.code_vld = vld_q;
  assign bus.period   = period_q;
  assign bus.err      = err_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_freq_code_detector.sv
// Directed bench for freq_code_detector: lock, code switch, range errors, timeout, extremes, reset.
module tb_freq_code_detector;
  import freq_code_detector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   err_cnt0 = 0;

  logic [CW-1:0] s_code;
  logic          s_vld;
  logic [PW-1:0] s_period;
  logic          s_err;
  logic          s_locked;
  logic [CW-1:0] t_code;
  logic          t_vld;
  logic          t_err;

  always #5 clk = ~clk;

  freq_code_detector_if b0 ();
  freq_code_detector_if b2 ();
  assign b0.pulse_in = pulse;
  assign b2.pulse_in = pulse;

  freq_code_detector #(.TOL(0), .LOCK_N(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  freq_code_detector #(.TOL(2), .LOCK_N(4)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  always @(negedge clk) if (b0.err === 1'b1) err_cnt0 <= err_cnt0 + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Rising edge now, high for 'high' cycles, next edge exactly p cycles later; snapshot after the edge cycle.
  task automatic send_period(input int p, input int high);
    pulse = 1'b1;
    tick();
    s_code = b0.code; s_vld = b0.code_vld; s_period = b0.period; s_err = b0.err; s_locked = b0.locked;
    t_code = b2.code; t_vld = b2.code_vld; t_err = b2.err;
    for (int i = 1; i < p; i++) begin
      if (i >= high) pulse = 1'b0;
      tick();
    end
    pulse = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    tests++; if (b0.code !== 3'd0)    begin fails++; $display("FAIL reset_code: got %0d want 0", b0.code); end
    tests++; if (b0.code_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", b0.code_vld); end
    tests++; if (b0.period !== 10'd0) begin fails++; $display("FAIL reset_period: got %0d want 0", b0.period); end
    tests++; if (b0.err !== 1'b0)     begin fails++; $display("FAIL reset_err: got %b want 0", b0.err); end
    tests++; if (b0.locked !== 1'b0)  begin fails++; $display("FAIL reset_locked: got %b want 0", b0.locked); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lock_code3;
    int e0;
    e0 = err_cnt0;
    for (int k = 0; k < 5; k++) begin
      send_period(416, 1);
      tests++; if (s_vld !== (k != 0)) begin fails++; $display("FAIL lock_vld e%0d: got %b want %b", k, s_vld, (k != 0)); end
      if (k != 0) begin
        tests++; if (s_code !== 3'd3) begin fails++; $display("FAIL lock_code e%0d: got %0d want 3", k, s_code); end
        tests++; if (s_period !== 10'd416) begin fails++; $display("FAIL lock_period e%0d: got %0d want 416", k, s_period); end
      end
      tests++; if (s_locked !== (k == 4)) begin fails++; $display("FAIL lock_locked e%0d: got %b want %b", k, s_locked, (k == 4)); end
    end
    tests++; if (err_cnt0 != e0) begin fails++; $display("FAIL lock_no_err: got %0d err pulses want 0", err_cnt0 - e0); end
  endtask

  task automatic test_code_switch;
    for (int k = 0; k < 5; k++) begin
      send_period(352, 3);
      tests++; if (s_code !== ((k == 0) ? 3'd3 : 3'd5)) begin fails++; $display("FAIL switch_code e%0d: got %0d want %0d", k, s_code, (k == 0) ? 3 : 5); end
      tests++; if (s_period !== ((k == 0) ? 10'd416 : 10'd352)) begin fails++; $display("FAIL switch_period e%0d: got %0d", k, s_period); end
      tests++; if (s_vld !== 1'b1) begin fails++; $display("FAIL switch_vld e%0d: got %b want 1", k, s_vld); end
      tests++; if (s_locked !== (k == 0 || k == 4)) begin fails++; $display("FAIL switch_locked e%0d: got %b want %b", k, s_locked, (k == 0 || k == 4)); end
    end
  endtask

  task automatic test_out_of_range;
    for (int k = 0; k < 3; k++) begin
      send_period(400, 1);
      tests++; if (s_err !== (k != 0)) begin fails++; $display("FAIL oor_err e%0d: got %b want %b", k, s_err, (k != 0)); end
      tests++; if (s_vld !== (k == 0)) begin fails++; $display("FAIL oor_vld e%0d: got %b want %b", k, s_vld, (k == 0)); end
      tests++; if (s_code !== 3'd5) begin fails++; $display("FAIL oor_code e%0d: got %0d want 5", k, s_code); end
      tests++; if (s_locked !== (k == 0)) begin fails++; $display("FAIL oor_locked e%0d: got %b want %b", k, s_locked, (k == 0)); end
      if (k != 0) begin
        tests++; if (s_period !== 10'd400) begin fails++; $display("FAIL oor_period e%0d: got %0d want 400", k, s_period); end
      end
    end
  endtask

  task automatic test_tolerance;
    for (int k = 0; k < 3; k++) begin
      send_period(418, 1);
      tests++; if (s_err !== 1'b1) begin fails++; $display("FAIL tol0_err e%0d: got %b want 1", k, s_err); end
      if (k != 0) begin
        tests++; if (s_code !== 3'd5) begin fails++; $display("FAIL tol0_code e%0d: got %0d want 5", k, s_code); end
        tests++; if (s_period !== 10'd418) begin fails++; $display("FAIL tol0_period e%0d: got %0d want 418", k, s_period); end
        tests++; if (t_code !== 3'd3) begin fails++; $display("FAIL tol2_code e%0d: got %0d want 3", k, t_code); end
        tests++; if (t_vld !== 1'b1) begin fails++; $display("FAIL tol2_vld e%0d: got %b want 1", k, t_vld); end
        tests++; if (t_err !== 1'b0) begin fails++; $display("FAIL tol2_err e%0d: got %b want 0", k, t_err); end
      end
    end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    for (int i = 1; i <= 512; i++) begin
      tick();
      if (b0.err === 1'b1) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL tmo_early: got %0d err pulses before 513 want 0", early); end
    tick();
    tests++; if (b0.err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1 at distance 513", b0.err); end
    tests++; if (b0.locked !== 1'b0) begin fails++; $display("FAIL tmo_locked: got %b want 0", b0.locked); end
    tick();
    tests++; if (b0.err !== 1'b0) begin fails++; $display("FAIL tmo_pulse: got %b want 0", b0.err); end
    send_period(512, 1);
    tests++; if (s_vld !== 1'b0 || s_err !== 1'b0) begin fails++; $display("FAIL tmo_first_edge: got vld=%b err=%b want 0 0", s_vld, s_err); end
    send_period(288, 1);
    tests++; if (s_vld !== 1'b1 || s_code !== 3'd0) begin fails++; $display("FAIL p512_code: got vld=%b code=%0d want 1 0", s_vld, s_code); end
    tests++; if (s_period !== 10'd512) begin fails++; $display("FAIL p512_period: got %0d want 512", s_period); end
  endtask

  task automatic test_extremes;
    send_period(287, 1);
    tests++; if (s_vld !== 1'b1 || s_code !== 3'd7 || s_err !== 1'b0) begin fails++; $display("FAIL p288_code: got vld=%b code=%0d err=%b want 1 7 0", s_vld, s_code, s_err); end
    send_period(256, 1);
    tests++; if (s_err !== 1'b1 || s_vld !== 1'b0 || s_code !== 3'd7) begin fails++; $display("FAIL p287_err: got err=%b vld=%b code=%0d want 1 0 7", s_err, s_vld, s_code); end
    send_period(416, 1);
    tests++; if (s_err !== 1'b1 || s_period !== 10'd256) begin fails++; $display("FAIL p256_err: got err=%b period=%0d want 1 256", s_err, s_period); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 5; k++) send_period(416, 1);
    tests++; if (s_locked !== 1'b1 || s_code !== 3'd3) begin fails++; $display("FAIL relock: got locked=%b code=%0d want 1 3", s_locked, s_code); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tests++; if ({b0.code, b0.code_vld, b0.period, b0.err, b0.locked} !== '0) begin fails++; $display("FAIL midreset_outs: got code=%0d vld=%b period=%0d err=%b locked=%b want all 0", b0.code, b0.code_vld, b0.period, b0.err, b0.locked); end
    send_period(416, 1);
    tests++; if (s_vld !== 1'b0 || s_err !== 1'b0) begin fails++; $display("FAIL postreset_first: got vld=%b err=%b want 0 0", s_vld, s_err); end
    send_period(416, 1);
    tests++; if (s_vld !== 1'b1 || s_code !== 3'd3 || s_period !== 10'd416 || s_locked !== 1'b0) begin fails++; $display("FAIL postreset_decode: got vld=%b code=%0d period=%0d locked=%b want 1 3 416 0", s_vld, s_code, s_period, s_locked); end
  endtask

  initial begin
    test_reset();
    test_lock_code3();
    test_code_switch();
    test_out_of_range();
    test_tolerance();
    test_timeout();
    test_extremes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
